// File: rtl/led_mode_ctrl.sv
// LED pattern controller: a debounced pushbutton steps through four display modes,
// and a prescaled tick advances the pattern of the current mode.
module led_mode_ctrl #(
    parameter int LEDS_NR   = 6,
    parameter int TICK_DIV  = 1000000,
    parameter int DB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key,
    output logic [LEDS_NR-1:0] led,
    output logic [1:0]         mode
);

    typedef enum logic [1:0] {
        M_COUNT = 2'd0,
        M_CHASE = 2'd1,
        M_BLINK = 2'd2,
        M_OFF   = 2'd3
    } mode_t;

    localparam int PC_W = $clog2(TICK_DIV);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [DB_W-1:0]    r_dbc;
    logic [PC_W-1:0]    r_pc;
    logic [LEDS_NR-1:0] r_pattern;
    mode_t              r_state;

    logic               w_db_done;
    logic               w_press;
    logic               w_tick;
    mode_t              w_next_mode;
    logic [LEDS_NR-1:0] w_rot;

    // A press is the debounced 0->1 transition, decided on the same edge stable flips.
    assign w_db_done   = (r_sync2 != r_stable) && (r_dbc == DB_LAST);
    assign w_press     = w_db_done && r_sync2;
    assign w_tick      = (r_pc == PC_LAST);
    assign w_next_mode = mode_t'(r_state + 2'd1);

    generate
        if (LEDS_NR == 1) begin : g_rot_single
            assign w_rot = r_pattern;
        end else begin : g_rot_multi
            assign w_rot = {r_pattern[LEDS_NR-2:0], r_pattern[LEDS_NR-1]};
        end
    endgenerate

    function automatic logic [LEDS_NR-1:0] init_pattern(input mode_t m);
        case (m)
            M_CHASE: init_pattern = LEDS_NR'(1);
            M_BLINK: init_pattern = '1;
            default: init_pattern = '0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_dbc    <= '0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_dbc <= '0;
            end else if (r_dbc == DB_LAST) begin
                r_stable <= r_sync2;
                r_dbc    <= '0;
            end else begin
                r_dbc <= r_dbc + DB_W'(1);
            end
        end
    end

    // Priority: reset, then press (discards a coincident tick), then OFF hold, then tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= M_COUNT;
            r_pc      <= '0;
            r_pattern <= '0;
        end else if (w_press) begin
            r_state   <= w_next_mode;
            r_pc      <= '0;
            r_pattern <= init_pattern(w_next_mode);
        end else if (r_state == M_OFF) begin
            r_pc      <= '0;
            r_pattern <= '0;
        end else if (w_tick) begin
            r_pc <= '0;
            case (r_state)
                M_COUNT: r_pattern <= r_pattern + LEDS_NR'(1);
                M_CHASE: r_pattern <= w_rot;
                M_BLINK: r_pattern <= ~r_pattern;
                default: r_pattern <= '0;
            endcase
        end else begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign led  = r_pattern;
    assign mode = r_state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed-vector bench for led_mode_ctrl with LEDS_NR=4, TICK_DIV=4, DB_CYCLES=3.
module tb_led_mode_ctrl;

    localparam int LEDS_NR   = 4;
    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               key;
    logic [LEDS_NR-1:0] led;
    logic [1:0]         mode;

    int n_vec = 0;
    int n_bad = 0;

    led_mode_ctrl #(
        .LEDS_NR  (LEDS_NR),
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .key (key),
        .led (led),
        .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic press();
        key = 1'b1;
        step(10);
        key = 1'b0;
        step(10);
    endtask

    initial begin
        rst = 1'b1;
        key = 1'b0;
        step(3);
        check("reset_led", 32'(led), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        rst = 1'b0;

        // Free-running COUNT: first tick on the 4th edge, wrap after 64 edges.
        step(3);
        check("count_pre_tick", 32'(led), 32'h0);
        step(1);
        check("count_first_tick", 32'(led), 32'h1);
        for (int j = 2; j <= 16; j++) begin
            step(4);
            check($sformatf("count_%0d", j), 32'(led), 32'(j % 16));
        end

        // Held key: mode changes on exactly the 5th sampling edge.
        key = 1'b1;
        step(4);
        check("latency_not_yet", 32'(mode), 32'h0);
        check("latency_led_tick", 32'(led), 32'h1);
        step(1);
        check("latency_mode", 32'(mode), 32'h1);
        check("chase_init", 32'(led), 32'h1);
        step(3);
        check("chase_hold", 32'(led), 32'h1);
        step(1);
        check("chase_0010", 32'(led), 32'h2);
        step(4);
        check("chase_0100", 32'(led), 32'h4);
        step(4);
        check("chase_1000", 32'(led), 32'h8);
        step(4);
        check("chase_wrap", 32'(led), 32'h1);
        check("chase_mode_held", 32'(mode), 32'h1);

        // Short glitches on key never reach the debounce threshold.
        do_reset();
        check("post_reset_mode", 32'(mode), 32'h0);
        for (int p = 0; p < 4; p++) begin
            key = 1'b1;
            step(2);
            key = 1'b0;
            step(3);
            check($sformatf("glitch_mode_%0d", p), 32'(mode), 32'h0);
        end
        check("glitch_count", 32'(led), 32'h5);
        step(4);
        check("glitch_count_next", 32'(led), 32'h6);
        check("glitch_mode_final", 32'(mode), 32'h0);

        // Full mode cycle with clean presses.
        do_reset();
        press();
        check("cycle_mode1", 32'(mode), 32'h1);
        key = 1'b1;
        step(5);
        check("cycle_mode2", 32'(mode), 32'h2);
        check("blink_init", 32'(led), 32'hF);
        step(4);
        check("blink_off_phase", 32'(led), 32'h0);
        step(1);
        key = 1'b0;
        step(3);
        check("blink_on_phase", 32'(led), 32'hF);
        step(7);
        key = 1'b1;
        step(5);
        check("cycle_mode3", 32'(mode), 32'h3);
        check("off_led", 32'(led), 32'h0);
        step(5);
        key = 1'b0;
        step(10);
        check("off_led_hold", 32'(led), 32'h0);
        check("off_mode_hold", 32'(mode), 32'h3);
        key = 1'b1;
        step(5);
        check("cycle_mode0", 32'(mode), 32'h0);
        check("count_restart", 32'(led), 32'h0);
        step(4);
        check("count_restart_tick", 32'(led), 32'h1);
        step(1);
        key = 1'b0;
        step(10);

        // Press lands on a tick edge with led = 0101: press wins, pc restarts.
        do_reset();
        step(19);
        check("coinc_pre", 32'(led), 32'h4);
        key = 1'b1;
        step(1);
        check("coinc_led5", 32'(led), 32'h5);
        step(4);
        check("coinc_mode", 32'(mode), 32'h1);
        check("coinc_led", 32'(led), 32'h1);
        step(3);
        check("coinc_pc_cleared", 32'(led), 32'h1);
        step(1);
        check("coinc_first_rot", 32'(led), 32'h2);
        key = 1'b0;
        step(10);

        // Reset mid-debounce in BLINK discards the partial count.
        do_reset();
        press();
        press();
        check("mid_rst_blink", 32'(mode), 32'h2);
        key = 1'b1;
        step(4);
        check("mid_rst_pre", 32'(mode), 32'h2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_mode", 32'(mode), 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        step(4);
        check("mid_rst_full_wait", 32'(mode), 32'h0);
        check("mid_rst_tick", 32'(led), 32'h1);
        step(1);
        check("mid_rst_press", 32'(mode), 32'h1);
        check("mid_rst_chase", 32'(led), 32'h1);
        key = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
